// File: rtl/ball_motion_ctrl.sv
// Ball motion controller: edge-detects hit/goal flags, runs SERVE/PLAY/SCORED and moves the ball once per frame.
// Outputs registered, events take effect 1 cycle after the input edge; no backpressure (collisions during cooldown are dropped).
module ball_motion_ctrl #(
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int BALL_SIZE       = 16,
  parameter int INIT_X          = 312,
  parameter int INIT_Y          = 232,
  parameter int SPEED_X         = 4,
  parameter int SPEED_Y         = 2,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int SERVE_FRAMES    = 60
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              startOfFrame,
  input  logic              collision,
  input  logic              doubleball,
  input  logic              goal_left,
  input  logic              goal_right,
  input  logic              X_direction,
  input  logic              Y_direction,
  output logic [10:0]       topLeftX,
  output logic [10:0]       topLeftY,
  output logic signed [7:0] speedX,
  output logic signed [7:0] speedY,
  output logic              ball_active,
  output logic              score_p1,
  output logic              score_p2,
  output logic              spawn_second
);

  typedef enum logic [1:0] {SERVE, PLAY, SCORED} state_t;

  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam int SW = $clog2(SERVE_FRAMES + 1);

  localparam logic [10:0]        INIT_XV    = 11'(INIT_X);
  localparam logic [10:0]        INIT_YV    = 11'(INIT_Y);
  localparam logic signed [7:0]  SPX        = 8'(SPEED_X);
  localparam logic signed [7:0]  SPY        = 8'(SPEED_Y);
  localparam logic signed [11:0] X_MAX      = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] Y_MAX      = 12'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0]        X_MAX_POS  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0]        Y_MAX_POS  = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [CW-1:0]      COOL_LOAD  = CW'(COOLDOWN_FRAMES);
  localparam logic [SW-1:0]      SERVE_LAST = SW'(SERVE_FRAMES - 1);

  state_t        state;
  logic [CW-1:0] cooldown;
  logic [SW-1:0] serve_cnt;
  logic          db_used;
  logic          prev_coll, prev_db, prev_gl, prev_gr;

  logic coll_ev, db_ev, gl_ev, gr_ev;
  assign coll_ev = collision  & ~prev_coll;
  assign db_ev   = doubleball & ~prev_db;
  assign gl_ev   = goal_left  & ~prev_gl;
  assign gr_ev   = goal_right & ~prev_gr;

  // 12-bit signed next position so underflow past the top/left edge shows as negative
  logic signed [11:0] nx, ny;
  assign nx = $signed({1'b0, topLeftX}) + $signed({{4{speedX[7]}}, speedX});
  assign ny = $signed({1'b0, topLeftY}) + $signed({{4{speedY[7]}}, speedY});

  logic [10:0] x_nxt, y_nxt;
  logic        x_flip, y_flip;

  always_comb begin
    x_nxt  = nx[10:0];
    x_flip = 1'b0;
    if (nx[11]) begin
      x_nxt  = 11'd0;
      x_flip = 1'b1;
    end else if (nx > X_MAX) begin
      x_nxt  = X_MAX_POS;
      x_flip = 1'b1;
    end
  end

  always_comb begin
    y_nxt  = ny[10:0];
    y_flip = 1'b0;
    if (ny[11]) begin
      y_nxt  = 11'd0;
      y_flip = 1'b1;
    end else if (ny > Y_MAX) begin
      y_nxt  = Y_MAX_POS;
      y_flip = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state        <= SERVE;
      topLeftX     <= INIT_XV;
      topLeftY     <= INIT_YV;
      speedX       <= SPX;
      speedY       <= '0;
      ball_active  <= 1'b0;
      score_p1     <= 1'b0;
      score_p2     <= 1'b0;
      spawn_second <= 1'b0;
      cooldown     <= '0;
      serve_cnt    <= '0;
      db_used      <= 1'b0;
      prev_coll    <= 1'b0;
      prev_db      <= 1'b0;
      prev_gl      <= 1'b0;
      prev_gr      <= 1'b0;
    end else begin
      prev_coll    <= collision;
      prev_db      <= doubleball;
      prev_gl      <= goal_left;
      prev_gr      <= goal_right;
      score_p1     <= 1'b0;
      score_p2     <= 1'b0;
      spawn_second <= 1'b0;

      if (startOfFrame && cooldown != '0)
        cooldown <= cooldown - CW'(1);

      case (state)
        SERVE: begin
          topLeftX <= INIT_XV;
          topLeftY <= INIT_YV;
          if (startOfFrame) begin
            if (serve_cnt == SERVE_LAST) begin
              serve_cnt   <= '0;
              state       <= PLAY;
              ball_active <= 1'b1;
            end else begin
              serve_cnt <= serve_cnt + SW'(1);
            end
          end
        end

        PLAY: begin
          if (gl_ev) begin
            score_p2    <= 1'b1;
            speedX      <= -SPX;
            ball_active <= 1'b0;
            state       <= SCORED;
          end else if (gr_ev) begin
            score_p1    <= 1'b1;
            speedX      <= SPX;
            ball_active <= 1'b0;
            state       <= SCORED;
          end else begin
            // Frame move uses the pre-event velocity; an event this cycle overrides any bounce flip
            if (startOfFrame) begin
              topLeftX <= x_nxt;
              topLeftY <= y_nxt;
              if (x_flip) speedX <= -speedX;
              if (y_flip) speedY <= -speedY;
            end
            if (coll_ev) begin
              if (cooldown == '0) begin
                speedX   <= -speedX;
                cooldown <= COOL_LOAD;
                case ({Y_direction, X_direction})
                  2'b00:   speedY <= '0;
                  2'b10:   speedY <= -SPY;
                  2'b11:   speedY <= SPY;
                  default: speedY <= speedY;
                endcase
              end
            end else if (db_ev && !db_used) begin
              spawn_second <= 1'b1;
              db_used      <= 1'b1;
            end
          end
        end

        SCORED: begin
          topLeftX <= INIT_XV;
          topLeftY <= INIT_YV;
          speedY   <= '0;
          db_used  <= 1'b0;
          state    <= SERVE;
        end

        default: state <= SERVE;
      endcase
    end
  end

endmodule
